// File: rtl/valu_seq.sv
`default_nettype none
// valu_seq: sequences one vector command through memory -> ALU -> memory and folds the ALU flags.
// Optional macro VALU_SEQ_CONV_ACC_EN: op 101 becomes a lane-wise accumulation with a single result write.
module valu_seq #(
   parameter int N  = 18,
   parameter int V  = 3,
   parameter int AW = 8,
   parameter int LW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [AW-1:0]     src_a,
   input  logic [AW-1:0]     src_b,
   input  logic [AW-1:0]     dst,
   input  logic [LW-1:0]     len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        flags,
   output logic              rd_en,
   output logic [AW-1:0]     rd_addr_a,
   output logic [AW-1:0]     rd_addr_b,
   input  logic [V*N-1:0]    rd_data_a,
   input  logic [V*N-1:0]    rd_data_b,
   output logic [2:0]        alu_c,
   output logic [V*N-1:0]    alu_a,
   output logic [V*N-1:0]    alu_b,
   input  logic [V*N-1:0]    alu_r,
   input  logic [3:0]        alu_f,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [V*N-1:0]    wr_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t           state;
   logic [AW-1:0]    dst_q;
   logic [LW-1:0]    len_q;
   logic [LW-1:0]    cnt;
   logic [LW-1:0]    idx1;
   logic             drain_cnt;
   logic             v1;
   logic             f_neg;
   logic             f_zero;
   logic             f_carry;
   logic             accept;
   logic             last_issue;
   logic             wr_fire;
   logic [AW-1:0]    wr_off;

   assign accept     = (state == IDLE) && start;
   assign last_issue = (cnt == len_q - LW'(1));
   assign flags      = {f_neg, f_zero, f_carry, 1'b0};
   assign alu_a      = v1 ? rd_data_a : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         alu_c     <= 3'b000;
         dst_q     <= '0;
         len_q     <= '0;
         cnt       <= '0;
         drain_cnt <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  alu_c     <= op;
                  dst_q     <= dst;
                  len_q     <= len;
                  busy      <= 1'b1;
                  rd_addr_a <= src_a;
                  rd_addr_b <= src_b;
                  cnt       <= '0;
                  if (op[2:1] == 2'b11) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= FIN;
                  end else if (len == '0) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     rd_en <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (last_issue) begin
                  rd_en     <= 1'b0;
                  drain_cnt <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  cnt       <= cnt + LW'(1);
                  rd_addr_a <= rd_addr_a + AW'(1);
                  rd_addr_b <= rd_addr_b + AW'(1);
               end
            end
            // Two cycles let the final beat pass the read and ALU stages before done.
            DRAIN: begin
               if (drain_cnt) begin
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            FIN: begin
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               alu_c <= 3'b000;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VALU_SEQ_CONV_ACC_EN
   logic             conv_mode;
   logic             last1;
   logic [V*N-1:0]   acc;

   assign conv_mode = (alu_c == 3'b101);
   assign alu_b     = !v1 ? '0 : (conv_mode ? acc : rd_data_b);
   assign wr_fire   = v1 && (!conv_mode || last1);
   assign wr_off    = conv_mode ? '0 : AW'(idx1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         last1 <= 1'b0;
      end else begin
         last1 <= rd_en && last_issue;
         if (accept) begin
            acc <= '0;
         end else if (v1 && conv_mode) begin
            acc <= alu_r;
         end
      end
   end
`else
   assign alu_b   = v1 ? rd_data_b : '0;
   assign wr_fire = v1;
   assign wr_off  = AW'(idx1);
`endif

   // v1 marks the cycle in which a beat's read data is at the ALU inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         idx1    <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         f_neg   <= 1'b0;
         f_zero  <= 1'b0;
         f_carry <= 1'b0;
      end else begin
         v1    <= rd_en;
         idx1  <= cnt;
         wr_en <= wr_fire;
         if (wr_fire) begin
            wr_addr <= dst_q + wr_off;
            wr_data <= alu_r;
         end
         if (accept) begin
            f_neg   <= 1'b0;
            f_zero  <= 1'b1;
            f_carry <= 1'b0;
         end else if (v1) begin
            f_neg   <= alu_f[3];
            f_zero  <= f_zero & alu_f[2];
            f_carry <= f_carry | alu_f[1];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_valu_seq.sv
`default_nettype none
// tb_valu_seq: directed self-checking bench for valu_seq with a behavioural memory and lane ALU.
module tb_valu_seq;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [7:0]    src_a, src_b, dst, len;
   logic          busy, done, err;
   logic [3:0]    flags;
   logic          rd_en;
   logic [7:0]    rd_addr_a, rd_addr_b;
   logic [53:0]   rd_data_a, rd_data_b;
   logic [2:0]    alu_c;
   logic [53:0]   alu_a, alu_b, alu_r;
   logic [3:0]    alu_f;
   logic          wr_en;
   logic [7:0]    wr_addr;
   logic [53:0]   wr_data;

   int errors = 0;
   int checks = 0;

   logic [53:0]   mem [0:255];

   valu_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .dst(dst), .len(len),
      .busy(busy), .done(done), .err(err), .flags(flags),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_f(alu_f),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_a <= mem[rd_addr_a];
         rd_data_b <= mem[rd_addr_b];
      end
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   function automatic logic [18:0] lane(input logic [2:0] c, input logic [17:0] a, input logic [17:0] b);
      logic [35:0] m;
      m = 36'(a) * 36'(b);
      case (c)
         3'b001:  lane = {a < b, a - b};
         3'b010:  lane = {1'b0, a & b};
         3'b011:  lane = {1'b0, a | b};
         3'b100:  lane = {|m[35:18], m[17:0]};
         default: lane = {1'b0, a} + {1'b0, b};
      endcase
   endfunction

   logic [2:0] lc;
   always_comb begin
      alu_r = '0;
      lc    = '0;
      for (int i = 0; i < 3; i++) begin
         {lc[i], alu_r[i*18 +: 18]} = lane(alu_c, alu_a[i*18 +: 18], alu_b[i*18 +: 18]);
      end
      alu_f = {alu_r[53], alu_r == 54'd0, |lc, 1'b0};
   end

   function automatic logic [53:0] pk(input int l0, input int l1, input int l2);
      return {l2[17:0], l1[17:0], l0[17:0]};
   endfunction

   // Observations gathered by run_cmd for one command.
   int            n_rd, n_wr, done_cyc, busy_bad;
   int            rd_cyc [16];
   int            wr_cyc [16];
   logic [7:0]    rda [16];
   logic [7:0]    rdb [16];
   logic [7:0]    wra [16];
   logic [53:0]   wrd [16];
   logic          done_err;
   logic [3:0]    done_flags;

   task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic [7:0] l, input int budget, input int inj);
      n_rd = 0; n_wr = 0; done_cyc = -1; busy_bad = 0; done_err = 1'bx; done_flags = 4'bx;
      for (int i = 0; i < 16; i++) begin
         rd_cyc[i] = -1; wr_cyc[i] = -1; rda[i] = '0; rdb[i] = '0; wra[i] = '0; wrd[i] = '0;
      end
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b; dst = d; len = l;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= budget && done_cyc < 0; c++) begin
         if (rd_en) begin
            if (n_rd < 16) begin rda[n_rd] = rd_addr_a; rdb[n_rd] = rd_addr_b; rd_cyc[n_rd] = c; end
            n_rd++;
         end
         if (wr_en) begin
            if (n_wr < 16) begin wra[n_wr] = wr_addr; wrd[n_wr] = wr_data; wr_cyc[n_wr] = c; end
            n_wr++;
         end
         if (busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin done_cyc = c; done_err = err; done_flags = flags; end
         if (c == inj) begin
            start = 1'b1; op = 3'b010; src_a = 8'h30; src_b = 8'h31; dst = 8'h00; len = 8'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; len = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err, rd_en, wr_en, flags} !== 9'd0) begin
         errors++; $display("FAIL reset_ctrl: got %b want 0", {busy, done, err, rd_en, wr_en, flags});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({rd_addr_a, rd_addr_b, wr_addr, alu_c} !== 27'd0 || wr_data !== 54'd0 ||
          alu_a !== 54'd0 || alu_b !== 54'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_data: ra=%h rb=%h wa=%h c=%b wd=%h a=%h b=%h busy=%b",
                            rd_addr_a, rd_addr_b, wr_addr, alu_c, wr_data, alu_a, alu_b, busy);
      end
   endtask

   task automatic test_add();
      for (int k = 0; k < 4; k++) begin
         mem[8'h10 + k] = pk(1 + k, 2 + k, 3 + k);
         mem[8'h20 + k] = pk(10, 10, 10);
      end
      run_cmd(3'b000, 8'h10, 8'h20, 8'h40, 8'd4, 20, 0);
      checks++;
      if (n_rd !== 4 || n_wr !== 4) begin
         errors++; $display("FAIL add_counts: reads=%0d writes=%0d want 4/4", n_rd, n_wr);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rda[i] !== 8'(8'h10 + i) || rdb[i] !== 8'(8'h20 + i) || rd_cyc[i] !== 1 + i) begin
            errors++; $display("FAIL add_read%0d: a=%h b=%h cyc=%0d want %h %h %0d",
                               i, rda[i], rdb[i], rd_cyc[i], 8'h10 + i, 8'h20 + i, 1 + i);
         end
         checks++;
         if (wra[i] !== 8'(8'h40 + i) || wrd[i] !== pk(11 + i, 12 + i, 13 + i) || wr_cyc[i] !== 3 + i) begin
            errors++; $display("FAIL add_write%0d: addr=%h data=%h cyc=%0d want %h %h %0d",
                               i, wra[i], wrd[i], wr_cyc[i], 8'h40 + i, pk(11 + i, 12 + i, 13 + i), 3 + i);
         end
      end
      checks++;
      if (done_cyc !== 7 || done_err !== 1'b0 || done_flags !== 4'b0000 || busy_bad !== 0) begin
         errors++; $display("FAIL add_done: cyc=%0d err=%b flags=%b busy_gaps=%0d want 7 0 0000 0",
                            done_cyc, done_err, done_flags, busy_bad);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mem[8'h43] !== pk(14, 15, 16)) begin
         errors++; $display("FAIL add_after: busy=%b done=%b mem43=%h", busy, done, mem[8'h43]);
      end
   endtask

   task automatic test_sub_zero();
      run_cmd(3'b001, 8'h10, 8'h10, 8'h48, 8'd2, 20, 0);
      checks++;
      if (n_wr !== 2 || wrd[0] !== 54'd0 || wrd[1] !== 54'd0 || wra[1] !== 8'h49) begin
         errors++; $display("FAIL sub_writes: n=%0d d0=%h d1=%h a1=%h want 2 0 0 49", n_wr, wrd[0], wrd[1], wra[1]);
      end
      checks++;
      if (done_cyc !== 5 || done_flags !== 4'b0100 || done_err !== 1'b0) begin
         errors++; $display("FAIL sub_done: cyc=%0d flags=%b err=%b want 5 0100 0", done_cyc, done_flags, done_err);
      end
   endtask

   task automatic test_carry();
      mem[8'h30] = pk(5, 0, 18'h3FFFF);
      mem[8'h31] = pk(1, 2, 1);
      run_cmd(3'b000, 8'h30, 8'h31, 8'h32, 8'd1, 20, 0);
      checks++;
      if (n_wr !== 1 || wrd[0] !== pk(6, 2, 0) || wra[0] !== 8'h32) begin
         errors++; $display("FAIL carry_write: n=%0d data=%h addr=%h want 1 %h 32", n_wr, wrd[0], wra[0], pk(6, 2, 0));
      end
      checks++;
      if (done_cyc !== 4 || done_flags !== 4'b0010) begin
         errors++; $display("FAIL carry_flags: cyc=%0d flags=%b want 4 0010", done_cyc, done_flags);
      end
   endtask

   task automatic test_illegal_and_empty();
      run_cmd(3'b111, 8'h10, 8'h20, 8'h40, 8'd5, 20, 0);
      checks++;
      if (n_rd !== 0 || n_wr !== 0 || done_cyc !== 1 || done_err !== 1'b1 || done_flags !== 4'b0100) begin
         errors++; $display("FAIL illegal_op: rd=%0d wr=%0d cyc=%0d err=%b flags=%b want 0 0 1 1 0100",
                            n_rd, n_wr, done_cyc, done_err, done_flags);
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL illegal_pulse: done=%b busy=%b err=%b want 0 0 0", done, busy, err);
      end
      run_cmd(3'b000, 8'h10, 8'h20, 8'h40, 8'd0, 20, 0);
      checks++;
      if (n_rd !== 0 || n_wr !== 0 || done_cyc !== 1 || done_err !== 1'b0 || done_flags !== 4'b0100) begin
         errors++; $display("FAIL len_zero: rd=%0d wr=%0d cyc=%0d err=%b flags=%b want 0 0 1 0 0100",
                            n_rd, n_wr, done_cyc, done_err, done_flags);
      end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 3; k++) begin
         mem[8'(8'hFE + k)] = pk(1 + k, 0, 0);
         mem[8'h80 + k]     = pk(0, 256, 0);
      end
      run_cmd(3'b011, 8'hFE, 8'h80, 8'h90, 8'd3, 20, 0);
      checks++;
      if (n_rd !== 3 || rda[0] !== 8'hFE || rda[1] !== 8'hFF || rda[2] !== 8'h00 || rdb[2] !== 8'h82) begin
         errors++; $display("FAIL wrap_addr: n=%0d a=%h %h %h b2=%h want 3 fe ff 00 82", n_rd, rda[0], rda[1], rda[2], rdb[2]);
      end
      checks++;
      if (n_wr !== 3 || wrd[2] !== pk(3, 256, 0) || wra[2] !== 8'h92 || done_flags !== 4'b0000) begin
         errors++; $display("FAIL wrap_data: n=%0d d2=%h a2=%h flags=%b", n_wr, wrd[2], wra[2], done_flags);
      end
   endtask

   task automatic test_ignore_start();
      run_cmd(3'b000, 8'h10, 8'h20, 8'h70, 8'd4, 20, 2);
      checks++;
      if (n_rd !== 4 || n_wr !== 4 || done_cyc !== 7) begin
         errors++; $display("FAIL ignore_counts: rd=%0d wr=%0d done=%0d want 4 4 7", n_rd, n_wr, done_cyc);
      end
      checks++;
      if (wra[3] !== 8'h73 || wrd[3] !== pk(14, 15, 16) || wrd[0] !== pk(11, 12, 13)) begin
         errors++; $display("FAIL ignore_data: a3=%h d3=%h d0=%h", wra[3], wrd[3], wrd[0]);
      end
   endtask

   task automatic test_conv();
      for (int k = 0; k < 3; k++) begin
         mem[8'h50 + k] = pk(1 + k, 1 + k, 1 + k);
         mem[8'hC0 + k] = pk(100, 100, 100);
      end
      run_cmd(3'b101, 8'h50, 8'hC0, 8'h60, 8'd3, 20, 0);
`ifdef VALU_SEQ_CONV_ACC_EN
      checks++;
      if (n_rd !== 3 || n_wr !== 1 || wra[0] !== 8'h60 || wrd[0] !== pk(6, 6, 6) || wr_cyc[0] !== 5) begin
         errors++; $display("FAIL conv_acc: rd=%0d wr=%0d addr=%h data=%h cyc=%0d want 3 1 60 %h 5",
                            n_rd, n_wr, wra[0], wrd[0], wr_cyc[0], pk(6, 6, 6));
      end
`else
      checks++;
      if (n_rd !== 3 || n_wr !== 3 || wra[2] !== 8'h62 || wrd[2] !== pk(103, 103, 103) || wrd[0] !== pk(101, 101, 101)) begin
         errors++; $display("FAIL conv_stream: rd=%0d wr=%0d a2=%h d2=%h d0=%h", n_rd, n_wr, wra[2], wrd[2], wrd[0]);
      end
`endif
      checks++;
      if (done_cyc !== 6 || done_flags !== 4'b0000 || done_err !== 1'b0) begin
         errors++; $display("FAIL conv_done: cyc=%0d flags=%b err=%b want 6 0000 0", done_cyc, done_flags, done_err);
      end
   endtask

   task automatic test_abort();
      int saw_done;
      saw_done = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b000; src_a = 8'h10; src_b = 8'h20; dst = 8'hA0; len = 8'd8;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL abort_pre: wr_en=%b busy=%b want 1 1", wr_en, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL abort_now: busy=%b wr_en=%b rd_en=%b done=%b want 0", busy, wr_en, rd_en, done);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done++;
         if (c == 2) rst_n = 1'b1;
      end
      checks++;
      if (saw_done !== 0) begin
         errors++; $display("FAIL abort_no_done: activity cycles=%0d want 0", saw_done);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      rd_data_a = '0; rd_data_b = '0;
      test_reset();
      test_add();
      test_sub_zero();
      test_carry();
      test_illegal_and_empty();
      test_wrap();
      test_ignore_start();
      test_conv();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
